// File: rtl/flt2int_pkg.sv
// Shared types and derived constants for the iterative float-to-integer converter.
package flt2int_pkg;

  typedef enum logic [2:0] {IDLE, DECODE, SHIFT, ROUND, DONE} state_t;
  typedef enum logic [1:0] {RND_TZ, RND_RNE, RND_FLOOR, RND_CEIL} rnd_t;

  function automatic int bias_f(input int exp_w);
    return (32'sd1 << (exp_w - 32'sd1)) - 32'sd1;
  endfunction

  // Beyond MAN_W+2 right shifts every mantissa bit already sits in guard/sticky.
  function automatic int shift_cap_f(input int man_w);
    return man_w + 32'sd2;
  endfunction

endpackage

// File: rtl/flt2int_round.sv
// Combinational rounding, sign application, saturation and status flags
// for the aligned magnitude held in the converter's work register.
module flt2int_round
  import flt2int_pkg::*;
#(
  parameter int INT_W = 16
) (
  input  logic [INT_W:0]   mag_i,
  input  logic             g_i,
  input  logic             s_i,
  input  logic             sign_i,
  input  rnd_t             rnd_i,
  input  logic             nan_path_i,
  input  logic             ovf_path_i,
  output logic [INT_W-1:0] res_o,
  output logic             ovf_o,
  output logic             nan_o,
  output logic             inexact_o
);

  localparam logic [INT_W:0]   POS_LIM = {2'b00, {(INT_W-1){1'b1}}};
  localparam logic [INT_W:0]   NEG_LIM = {2'b01, {(INT_W-1){1'b0}}};
  localparam logic [INT_W-1:0] POS_SAT = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] NEG_SAT = {1'b1, {(INT_W-1){1'b0}}};

  logic             round_up_s;
  logic [INT_W:0]   mag_r_s;
  logic [INT_W-1:0] mag_lo_s;

  // Round-up decision, increment, negate and saturate.
  always_comb begin
    round_up_s = 1'b0;
    res_o      = '0;
    ovf_o      = 1'b0;
    nan_o      = 1'b0;
    inexact_o  = 1'b0;
    case (rnd_i)
      RND_TZ:    round_up_s = 1'b0;
      RND_RNE:   round_up_s = g_i & (s_i | mag_i[0]);
      RND_FLOOR: round_up_s = sign_i & (g_i | s_i);
      RND_CEIL:  round_up_s = ~sign_i & (g_i | s_i);
      default:   round_up_s = 1'b0;
    endcase
    mag_r_s  = mag_i + {{INT_W{1'b0}}, round_up_s};
    mag_lo_s = mag_r_s[INT_W-1:0];
    if (nan_path_i) begin
      nan_o = 1'b1;
    end else if (ovf_path_i) begin
      res_o = sign_i ? NEG_SAT : POS_SAT;
      ovf_o = 1'b1;
    end else if (!sign_i && (mag_r_s > POS_LIM)) begin
      res_o = POS_SAT;
      ovf_o = 1'b1;
    end else if (sign_i && (mag_r_s > NEG_LIM)) begin
      res_o = NEG_SAT;
      ovf_o = 1'b1;
    end else begin
      res_o     = sign_i ? (~mag_lo_s + {{(INT_W-1){1'b0}}, 1'b1}) : mag_lo_s;
      inexact_o = g_i | s_i;
    end
  end

endmodule

// File: rtl/flt2int_iter.sv
// Multi-cycle float-to-integer converter: decode, one-bit-per-cycle alignment,
// then a single rounding cycle; req/ack handshake with status flags.
module flt2int_iter
  import flt2int_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int INT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req,
  input  logic [EXP_W+MAN_W:0]   flt_in,
  input  logic [1:0]             rnd_mode,
  output logic [INT_W-1:0]       int_out,
  output logic                   ack,
  output logic                   busy,
  output logic                   ovf,
  output logic                   nan,
  output logic                   inexact
);

  localparam int BIAS  = bias_f(EXP_W);
  localparam int CAP   = shift_cap_f(MAN_W);
  localparam int CNT_W = $clog2(CAP + INT_W + 1);
  localparam int MAG_W = INT_W + 1;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [MAN_W-1:0]   frac_q, frac_d;
  rnd_t               rnd_q, rnd_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic               g_q, g_d, s_q, s_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               left_q, left_d;
  logic               nan_path_q, nan_path_d, ovf_path_q, ovf_path_d;
  logic [INT_W-1:0]   int_out_q, int_out_d;
  logic               ack_q, ack_d, busy_q, busy_d;
  logic               ovf_q, ovf_d, nan_q, nan_d, inexact_q, inexact_d;
  logic [INT_W-1:0]   rnd_res_s;
  logic               rnd_ovf_s, rnd_nan_s, rnd_inexact_s;
  int                 e_v, n_v;

  flt2int_round #(.INT_W(INT_W)) u_round (
    .mag_i      (mag_q),
    .g_i        (g_q),
    .s_i        (s_q),
    .sign_i     (sign_q),
    .rnd_i      (rnd_q),
    .nan_path_i (nan_path_q),
    .ovf_path_i (ovf_path_q),
    .res_o      (rnd_res_s),
    .ovf_o      (rnd_ovf_s),
    .nan_o      (rnd_nan_s),
    .inexact_o  (rnd_inexact_s)
  );

  // Next-state and datapath update for the converter FSM.
  always_comb begin
    state_d = state_q;  sign_d = sign_q;  exp_d = exp_q;  frac_d = frac_q;
    rnd_d = rnd_q;  mag_d = mag_q;  g_d = g_q;  s_d = s_q;  cnt_d = cnt_q;
    left_d = left_q;  nan_path_d = nan_path_q;  ovf_path_d = ovf_path_q;
    int_out_d = int_out_q;  ack_d = ack_q;  busy_d = busy_q;
    ovf_d = ovf_q;  nan_d = nan_q;  inexact_d = inexact_q;
    e_v = 32'sd0;
    n_v = 32'sd0;
    case (state_q)
      IDLE, DONE: begin
        if (req) begin
          {sign_d, exp_d, frac_d} = flt_in;
          rnd_d     = rnd_t'(rnd_mode);
          ack_d     = 1'b0;
          busy_d    = 1'b1;
          ovf_d     = 1'b0;
          nan_d     = 1'b0;
          inexact_d = 1'b0;
          state_d   = DECODE;
        end else begin
          state_d = state_q;
        end
      end
      DECODE: begin
        mag_d      = MAG_W'({exp_q != '0, frac_q});
        g_d        = 1'b0;
        s_d        = 1'b0;
        nan_path_d = 1'b0;
        ovf_path_d = 1'b0;
        left_d     = 1'b0;
        cnt_d      = '0;
        // Zero/denormal operands use the minimum normal exponent.
        e_v = (exp_q == '0) ? (32'sd1 - BIAS) : (int'(exp_q) - BIAS);
        if (exp_q == '1) begin
          nan_path_d = (frac_q != '0);
          ovf_path_d = (frac_q == '0);
          state_d    = ROUND;
        end else if (e_v >= INT_W) begin
          ovf_path_d = 1'b1;
          state_d    = ROUND;
        end else begin
          if (e_v >= MAN_W) begin
            left_d = 1'b1;
            n_v    = e_v - MAN_W;
          end else begin
            left_d = 1'b0;
            n_v    = ((MAN_W - e_v) > CAP) ? CAP : (MAN_W - e_v);
          end
          cnt_d   = CNT_W'(n_v);
          state_d = (n_v == 32'sd0) ? ROUND : SHIFT;
        end
      end
      SHIFT: begin
        if (left_q) begin
          mag_d = {mag_q[MAG_W-2:0], 1'b0};
        end else begin
          mag_d = {1'b0, mag_q[MAG_W-1:1]};
          g_d   = mag_q[0];
          s_d   = s_q | g_q;
        end
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = (cnt_q == CNT_W'(1)) ? ROUND : SHIFT;
      end
      ROUND: begin
        int_out_d = rnd_res_s;
        ovf_d     = rnd_ovf_s;
        nan_d     = rnd_nan_s;
        inexact_d = rnd_inexact_s;
        ack_d     = 1'b1;
        busy_d    = 1'b0;
        state_d   = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, work and output registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;  sign_q <= 1'b0;  exp_q <= '0;  frac_q <= '0;
      rnd_q <= RND_TZ;  mag_q <= '0;  g_q <= 1'b0;  s_q <= 1'b0;  cnt_q <= '0;
      left_q <= 1'b0;  nan_path_q <= 1'b0;  ovf_path_q <= 1'b0;
      int_out_q <= '0;  ack_q <= 1'b0;  busy_q <= 1'b0;
      ovf_q <= 1'b0;  nan_q <= 1'b0;  inexact_q <= 1'b0;
    end else begin
      state_q <= state_d;  sign_q <= sign_d;  exp_q <= exp_d;  frac_q <= frac_d;
      rnd_q <= rnd_d;  mag_q <= mag_d;  g_q <= g_d;  s_q <= s_d;  cnt_q <= cnt_d;
      left_q <= left_d;  nan_path_q <= nan_path_d;  ovf_path_q <= ovf_path_d;
      int_out_q <= int_out_d;  ack_q <= ack_d;  busy_q <= busy_d;
      ovf_q <= ovf_d;  nan_q <= nan_d;  inexact_q <= inexact_d;
    end
  end

  assign int_out = int_out_q;
  assign ack     = ack_q;
  assign busy    = busy_q;
  assign ovf     = ovf_q;
  assign nan     = nan_q;
  assign inexact = inexact_q;

endmodule

// File: tb/tb_flt2int_iter.sv
// Scoreboard bench for flt2int_iter at half-precision to int16 defaults.
module tb_flt2int_iter;

  localparam logic [1:0] TZ = 2'b00, RNE = 2'b01, FLR = 2'b10, CEIL = 2'b11;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  flags;   // {ovf, nan, inexact}
    int          lat;     // ack edge index, the accept edge counting as 1
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [15:0] flt_in = 16'h0000;
  logic [1:0]  rnd_mode = 2'b00;
  logic [15:0] int_out;
  logic        ack, busy, ovf, nan, inexact;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  flt2int_iter dut (
    .clk(clk), .reset(reset), .req(req), .flt_in(flt_in), .rnd_mode(rnd_mode),
    .int_out(int_out), .ack(ack), .busy(busy), .ovf(ovf), .nan(nan), .inexact(inexact)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Issue one operation, optionally re-pulse req while it is shifting, then score the result.
  task automatic run_op(input string tag, input logic [15:0] f, input logic [1:0] rm,
                        input logic [15:0] er, input logic [2:0] ef, input int el, input bit poke);
    exp_t e;
    exp_t got_e;
    int   edges;
    bit   seen;
    e.res = er;  e.flags = ef;  e.lat = el;
    sb_q.push_back(e);
    @(negedge clk);
    flt_in = f;  rnd_mode = rm;  req = 1'b1;
    @(posedge clk);
    edges = 1;
    #1;
    check_eq({tag, ".ack_clr"}, {31'd0, ack}, 32'd0);
    check_eq({tag, ".busy"}, {31'd0, busy}, 32'd1);
    req = 1'b0;  flt_in = 16'h0000;
    seen = 1'b0;
    while (!seen && edges < 60) begin
      if (poke && edges == 4) begin
        req = 1'b1;  flt_in = 16'h4700;  rnd_mode = TZ;
      end else begin
        req = 1'b0;
      end
      @(posedge clk);
      edges++;
      #1;
      seen = ack;
    end
    req = 1'b0;
    got_e = sb_q.pop_front();
    if (!seen) begin
      check_eq({tag, ".timeout"}, 32'd0, 32'd1);
    end else begin
      check_eq({tag, ".int_out"}, {16'd0, int_out}, {16'd0, got_e.res});
      check_eq({tag, ".flags"}, {29'd0, ovf, nan, inexact}, {29'd0, got_e.flags});
      check_eq({tag, ".latency"}, edges, got_e.lat);
      check_eq({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.int_out", {16'd0, int_out}, 32'd0);
    check_eq("rst.ctl", {27'd0, ack, busy, ovf, nan, inexact}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("one_rne",   16'h3C00, RNE,  16'h0001, 3'b000, 13, 1'b0);
    run_op("1p5_tz",    16'h3E00, TZ,   16'h0001, 3'b001, 13, 1'b0);
    run_op("1p5_rne",   16'h3E00, RNE,  16'h0002, 3'b001, 13, 1'b0);
    run_op("2p5_rne",   16'h4100, RNE,  16'h0002, 3'b001, 12, 1'b0);
    run_op("m2p5_flr",  16'hC100, FLR,  16'hFFFD, 3'b001, 12, 1'b0);
    run_op("m2p5_ceil", 16'hC100, CEIL, 16'hFFFE, 3'b001, 12, 1'b0);
    run_op("max_half",  16'h7BFF, TZ,   16'h7FFF, 3'b100,  8, 1'b0);
    run_op("min_int",   16'hF800, TZ,   16'h8000, 3'b000,  8, 1'b0);
    run_op("below_min", 16'hF801, TZ,   16'h8000, 3'b100,  8, 1'b0);
    run_op("pos_inf",   16'h7C00, RNE,  16'h7FFF, 3'b100,  3, 1'b0);
    run_op("neg_inf",   16'hFC00, RNE,  16'h8000, 3'b100,  3, 1'b0);
    run_op("nan",       16'h7E00, RNE,  16'h0000, 3'b010,  3, 1'b0);
    run_op("den_ceil",  16'h0001, CEIL, 16'h0001, 3'b001, 15, 1'b0);
    run_op("den_tz",    16'h0001, TZ,   16'h0000, 3'b001, 15, 1'b0);
    run_op("neg_zero",  16'h8000, TZ,   16'h0000, 3'b000, 15, 1'b0);
    run_op("req_shift", 16'h3C00, RNE,  16'h0001, 3'b000, 13, 1'b1);
    run_op("min_again", 16'hF800, TZ,   16'h8000, 3'b000,  8, 1'b0);

    // Abort an operation mid-shift; outputs must clear without waiting for a clock.
    @(negedge clk);
    flt_in = 16'h3C00;  rnd_mode = RNE;  req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_eq("abort.int_out", {16'd0, int_out}, 32'd0);
    check_eq("abort.ctl", {27'd0, ack, busy, ovf, nan, inexact}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("seven", 16'h4700, TZ, 16'h0007, 3'b000, 11, 1'b0);

    check_eq("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
